sel_button_ctrl: RTL

//  Upstream control stage for the pattern display top level. Converts one raw

---
 rtl/sel_ctrl_pkg.sv | 25 ++
 rtl/btn_debounce.sv | 50 +++++
 rtl/sel_button_ctrl.sv | 123 ++++++++++++
 3 files changed

// File: rtl/sel_ctrl_pkg.sv
// Package: sel_ctrl_pkg
// Purpose: Shared types and helpers for the pattern-select button controller.
//   - sel_state_e : press-tracking FSM encoding
//   - SEL_W       : width of the pattern select
//   - next_sel()  : wrapping advance shared by the press and auto-cycle paths
package sel_ctrl_pkg;

    localparam int unsigned SEL_W = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESSED = 2'd1,
        ST_HELD    = 2'd2
    } sel_state_e;

    // Advance the select, wrapping to 0 after the last pattern.
    function automatic logic [SEL_W-1:0] next_sel(input logic [SEL_W-1:0] cur,
                                                  input int unsigned       num);
        if (32'(cur) >= num - 1) begin
            return '0;
        end
        return cur + 1'b1;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Module: btn_debounce
// Purpose: Two-flop synchroniser followed by a counting debouncer for one raw button.
// Ports:
//   i_clk   in  system clock
//   i_rst   in  synchronous reset, active-low
//   i_raw   in  raw asynchronous button level
//   o_level out debounced level; follows a steady input DB_CYCLES+2 clocks later
module btn_debounce #(
    parameter int unsigned DB_CYCLES = 8
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_raw,
    output logic o_level
);

    localparam int unsigned CntW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(DB_CYCLES - 1);

    logic            sync1_q;
    logic            sync2_q;
    logic            level_q;
    logic [CntW-1:0] cnt_q;

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= i_raw;
            sync2_q <= sync1_q;
            // Any cycle of agreement restarts the count, so short glitches never flip the level.
            if (sync2_q != level_q) begin
                if (cnt_q == CntMax) begin
                    level_q <= sync2_q;
                    cnt_q   <= '0;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end else begin
                cnt_q <= '0;
            end
        end
    end

    assign o_level = level_q;

endmodule

// File: rtl/sel_button_ctrl.sv
// Module: sel_button_ctrl
// Purpose: Turns one push-button into the 2-bit pattern select for the pattern mux.
//   Short press advances the pattern, long press returns to pattern 0.
//   Optional feature macro: SEL_AUTO_CYCLE_EN -- auto-advance every AUTO_TICKS i_tick pulses
//   while the button is idle. Without it i_tick is ignored; the port list is the same.
// Ports:
//   i_clk     in  system clock
//   i_rst     in  synchronous reset, active-low
//   i_btn     in  raw push-button, 1 = pressed
//   i_tick    in  one-clock slow strobe (auto-cycle only)
//   o_sel     out pattern select
//   o_sel_chg out one-clock pulse in the cycle o_sel takes a new value
//   o_btn_db  out debounced button level
module sel_button_ctrl
    import sel_ctrl_pkg::*;
#(
    parameter int unsigned DB_CYCLES    = 8,
    parameter int unsigned HOLD_CYCLES  = 64,
    parameter int unsigned NUM_PATTERNS = 4,
    parameter int unsigned AUTO_TICKS   = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_btn,
    input  logic             i_tick,
    output logic [SEL_W-1:0] o_sel,
    output logic             o_sel_chg,
    output logic             o_btn_db
);

    localparam int unsigned HoldW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HoldW-1:0] HoldMax = HoldW'(HOLD_CYCLES - 1);

    logic btn_db;

    btn_debounce #(
        .DB_CYCLES (DB_CYCLES)
    ) u_debounce (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_raw   (i_btn),
        .o_level (btn_db)
    );

    sel_state_e       state_q;
    logic [HoldW-1:0] hold_cnt_q;
    logic [SEL_W-1:0] sel_q;
    logic             sel_chg_q;

`ifdef SEL_AUTO_CYCLE_EN
    localparam int unsigned AutoW = (AUTO_TICKS > 1) ? $clog2(AUTO_TICKS) : 1;
    localparam logic [AutoW-1:0] AutoMax = AutoW'(AUTO_TICKS - 1);
    logic [AutoW-1:0] auto_cnt_q;
`else
    logic unused_cfg;
    assign unused_cfg = i_tick ^ (AUTO_TICKS == 0);
`endif

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state_q    <= ST_IDLE;
            hold_cnt_q <= '0;
            sel_q      <= '0;
            sel_chg_q  <= 1'b0;
`ifdef SEL_AUTO_CYCLE_EN
            auto_cnt_q <= '0;
`endif
        end else begin
            sel_chg_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (btn_db) begin
                        state_q    <= ST_PRESSED;
                        hold_cnt_q <= '0;
`ifdef SEL_AUTO_CYCLE_EN
                        auto_cnt_q <= '0;
`endif
                    end
`ifdef SEL_AUTO_CYCLE_EN
                    else if (i_tick) begin
                        if (auto_cnt_q == AutoMax) begin
                            sel_q      <= next_sel(sel_q, NUM_PATTERNS);
                            sel_chg_q  <= 1'b1;
                            auto_cnt_q <= '0;
                        end else begin
                            auto_cnt_q <= auto_cnt_q + 1'b1;
                        end
                    end
`endif
                end
                ST_PRESSED: begin
                    if (!btn_db) begin
                        // Short press; ticks are not counted here so the press is the only advance.
                        state_q   <= ST_IDLE;
                        sel_q     <= next_sel(sel_q, NUM_PATTERNS);
                        sel_chg_q <= 1'b1;
`ifdef SEL_AUTO_CYCLE_EN
                        auto_cnt_q <= '0;
`endif
                    end else if (hold_cnt_q == HoldMax) begin
                        // Long press: forced to 0 and flagged even if already 0.
                        state_q   <= ST_HELD;
                        sel_q     <= '0;
                        sel_chg_q <= 1'b1;
                    end else begin
                        hold_cnt_q <= hold_cnt_q + 1'b1;
                    end
                end
                ST_HELD: begin
                    if (!btn_db) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign o_sel     = sel_q;
    assign o_sel_chg = sel_chg_q;
    assign o_btn_db  = btn_db;

endmodule
